// File: rtl/post_adder_stage.sv
// DSP48A1 post-adder stage: optional CYI carry-in register, 48-bit add/subtract of Z and X,
// and optional P / CARRYOUT output registers with synchronous resets and clock enables.
module post_adder_stage #(
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter int WIDTH       = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rstcarryin,
  input  logic             rstp,
  input  logic             cecarryin,
  input  logic             cep,
  input  logic             carryin_sel,
  input  logic             opmode7,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] z_in,
  output logic [WIDTH-1:0] p,
  output logic             carryout,
  output logic             carryoutf
);

  logic             w_cin;
  logic [WIDTH:0]   w_xc;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_co;

  generate
    if (CARRYINREG != 0) begin : g_cyi_reg
      logic r_cyi;
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_cyi <= 1'b0;
        else if (rstcarryin) r_cyi <= 1'b0;
        else if (cecarryin)  r_cyi <= carryin_sel;
      end
      assign w_cin = r_cyi;
    end else begin : g_cyi_byp
      assign w_cin = carryin_sel;
    end
  endgenerate

  // One extra bit on the operands: its value after the add/subtract is the carry or borrow.
  always_comb begin
    w_xc  = {1'b0, x_in} + {{WIDTH{1'b0}}, w_cin};
    w_sum = opmode7 ? ({1'b0, z_in} - w_xc) : ({1'b0, z_in} + w_xc);
  end

  assign w_result = w_sum[WIDTH-1:0];
  assign w_co     = w_sum[WIDTH];

  generate
    if (PREG != 0) begin : g_p_reg
      logic [WIDTH-1:0] r_p;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_p <= '0;
        else if (rstp) r_p <= '0;
        else if (cep)  r_p <= w_result;
      end
      assign p = r_p;
    end else begin : g_p_byp
      assign p = w_result;
    end

    if (CARRYOUTREG != 0) begin : g_co_reg
      logic r_co;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       r_co <= 1'b0;
        else if (rstp) r_co <= 1'b0;
        else if (cep)  r_co <= w_co;
      end
      assign carryout = r_co;
    end else begin : g_co_byp
      assign carryout = w_co;
    end
  endgenerate

  assign carryoutf = carryout;

endmodule

// File: tb/tb_post_adder_stage.sv
// Bench for post_adder_stage: fully registered instance plus an all-bypass instance,
// vector table, hand-written corner sequences and a randomized run against an arithmetic model.
module tb_post_adder_stage;

  localparam int W = 48;
  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  logic         clk = 1'b0;
  logic         rst, rstcarryin, rstp, cecarryin, cep, carryin_sel, opmode7;
  logic [W-1:0] x_in, z_in;
  logic [W-1:0] p, p_b;
  logic         carryout, carryoutf, carryout_b, carryoutf_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  post_adder_stage #(.CARRYINREG(1), .PREG(1), .CARRYOUTREG(1), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .rstcarryin(rstcarryin), .rstp(rstp),
    .cecarryin(cecarryin), .cep(cep), .carryin_sel(carryin_sel), .opmode7(opmode7),
    .x_in(x_in), .z_in(z_in), .p(p), .carryout(carryout), .carryoutf(carryoutf)
  );

  post_adder_stage #(.CARRYINREG(0), .PREG(0), .CARRYOUTREG(0), .WIDTH(W)) dut_byp (
    .clk(clk), .rst(rst), .rstcarryin(rstcarryin), .rstp(rstp),
    .cecarryin(cecarryin), .cep(cep), .carryin_sel(carryin_sel), .opmode7(opmode7),
    .x_in(x_in), .z_in(z_in), .p(p_b), .carryout(carryout_b), .carryoutf(carryoutf_b)
  );

  typedef struct {
    logic         sel;
    logic         op;
    logic [W-1:0] x;
    logic [W-1:0] z;
    logic [W-1:0] exp_p;
    logic         exp_co;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: exact integer sum or difference, then reduced modulo 2^W.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] z,
                                       input logic op, input logic cin);
    logic [63:0] xs, zs, t, r;
    logic        c;
    xs = 64'(x);
    zs = 64'(z);
    t  = xs + 64'(cin);
    if (!op) begin
      r = zs + t;
      c = (r >= (64'd1 << W));
      if (c) r = r - (64'd1 << W);
    end else begin
      c = (zs < t);
      r = c ? (zs + (64'd1 << W) - t) : (zs - t);
    end
    return {c, r[W-1:0]};
  endfunction

  vec_t        vecs[6];
  logic [W:0]  m;
  logic [W-1:0] m_p;
  logic        m_co, m_cyi;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 48'h5,       48'h3,  48'h9,   1'b0};
    vecs[1] = '{1'b0, 1'b0, ALL1,        48'h1,  48'h0,   1'b1};
    vecs[2] = '{1'b1, 1'b1, 48'h2,       48'h2,  ALL1,    1'b1};
    vecs[3] = '{1'b1, 1'b1, 48'h2,       48'h10, 48'hD,   1'b0};
    vecs[4] = '{1'b1, 1'b0, ALL1,        ALL1,   ALL1,    1'b1};
    vecs[5] = '{1'b0, 1'b1, 48'h5,       48'h5,  48'h0,   1'b0};

    rst = 1'b1; rstcarryin = 1'b0; rstp = 1'b0; cecarryin = 1'b0; cep = 1'b0;
    carryin_sel = 1'b0; opmode7 = 1'b0; x_in = '0; z_in = '0;
    tick(); tick();
    check("reset_p", 64'(p), 64'h0);
    check("reset_co", 64'(carryout), 64'h0);
    check("reset_cof", 64'(carryoutf), 64'h0);
    rst = 1'b0;

    // Vector table: carry-in one cycle ahead of the operands.
    for (int i = 0; i < 6; i++) begin
      carryin_sel = vecs[i].sel; cecarryin = 1'b1; cep = 1'b1;
      opmode7 = 1'b0; x_in = '0; z_in = '0;
      tick();
      x_in = vecs[i].x; z_in = vecs[i].z; opmode7 = vecs[i].op;
      #1;
      check($sformatf("byp_vec%0d_p", i), 64'(p_b), 64'(vecs[i].exp_p));
      check($sformatf("byp_vec%0d_co", i), 64'(carryout_b), 64'(vecs[i].exp_co));
      tick();
      check($sformatf("vec%0d_p", i), 64'(p), 64'(vecs[i].exp_p));
      check($sformatf("vec%0d_co", i), 64'(carryout), 64'(vecs[i].exp_co));
      check($sformatf("vec%0d_cof", i), 64'(carryoutf), 64'(vecs[i].exp_co));
    end

    // Async reset mid-cycle with nonzero inputs; bypass instance is unaffected.
    carryin_sel = 1'b1; cecarryin = 1'b1; cep = 1'b1; opmode7 = 1'b0;
    x_in = 48'h7; z_in = 48'h8;
    tick();
    tick();
    check("pre_rst_p", 64'(p), 64'h10);
    #2 rst = 1'b1;
    #1;
    check("async_rst_p", 64'(p), 64'h0);
    check("async_rst_co", 64'(carryout), 64'h0);
    check("async_rst_cof", 64'(carryoutf), 64'h0);
    check("byp_rst_p", 64'(p_b), 64'h10);
    tick();
    check("rst_held_p", 64'(p), 64'h0);
    rst = 1'b0; cecarryin = 1'b0; x_in = 48'h5; z_in = '0;
    tick();
    check("cyi_cleared_p", 64'(p), 64'h5);

    // Clock-enable hold on P/CARRYOUT, then sync reset beating the enable.
    cecarryin = 1'b1; carryin_sel = 1'b1; x_in = ALL1; z_in = 48'h1;
    tick();
    check("hold_setup_p", 64'(p), 64'h0);
    check("hold_setup_co", 64'(carryout), 64'h1);
    cep = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_in = W'({$urandom, $urandom}); z_in = W'({$urandom, $urandom});
      opmode7 = 1'($urandom);
      tick();
      check($sformatf("cep_hold%0d_p", i), 64'(p), 64'h0);
      check($sformatf("cep_hold%0d_co", i), 64'(carryout), 64'h1);
    end
    rstp = 1'b1; cep = 1'b1;
    tick();
    check("rstp_prio_p", 64'(p), 64'h0);
    check("rstp_prio_co", 64'(carryout), 64'h0);
    rstp = 1'b0;

    // CYI holds when cecarryin is low (current CYI = 1).
    cecarryin = 1'b0; carryin_sel = 1'b0; opmode7 = 1'b0; x_in = '0; z_in = '0;
    tick();
    check("cyi_hold0_p", 64'(p), 64'h1);
    carryin_sel = 1'b1;
    tick();
    carryin_sel = 1'b0;
    tick();
    check("cyi_hold1_p", 64'(p), 64'h1);

    // rstcarryin beats cecarryin.
    rstcarryin = 1'b1; cecarryin = 1'b1; carryin_sel = 1'b1; z_in = 48'h4;
    tick();
    rstcarryin = 1'b0; cecarryin = 1'b0;
    tick();
    check("rstcarryin_prio_p", 64'(p), 64'h4);

    // Randomized run against the model.
    rstcarryin = 1'b1; rstp = 1'b1;
    tick();
    m_cyi = 1'b0; m_p = '0; m_co = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rstcarryin  = ($urandom_range(0, 15) == 0);
      rstp        = ($urandom_range(0, 15) == 0);
      cecarryin   = ($urandom_range(0, 3) != 0);
      cep         = ($urandom_range(0, 3) != 0);
      carryin_sel = 1'($urandom);
      opmode7     = 1'($urandom);
      x_in        = ($urandom_range(0, 7) == 0) ? ALL1 : W'({$urandom, $urandom});
      z_in        = ($urandom_range(0, 7) == 0) ? x_in : W'({$urandom, $urandom});
      #1;
      m = model(x_in, z_in, opmode7, carryin_sel);
      check($sformatf("rnd%0d_byp_p", i), 64'(p_b), 64'(m[W-1:0]));
      check($sformatf("rnd%0d_byp_co", i), 64'(carryout_b), 64'(m[W]));
      m = model(x_in, z_in, opmode7, m_cyi);
      if (rstp) begin
        m_p = '0; m_co = 1'b0;
      end else if (cep) begin
        m_p = m[W-1:0]; m_co = m[W];
      end
      if (rstcarryin)     m_cyi = 1'b0;
      else if (cecarryin) m_cyi = carryin_sel;
      tick();
      check($sformatf("rnd%0d_p", i), 64'(p), 64'(m_p));
      check($sformatf("rnd%0d_co", i), 64'(carryout), 64'(m_co));
      check($sformatf("rnd%0d_cof", i), 64'(carryoutf), 64'(m_co));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/post_adder_stage.md
Name: post_adder_stage

Overview:
- Downstream neighbour of the carry-in select stage in the DSP48A1 datapath.
- Registers the selected carry-in (CYI register), performs the 48-bit post-adder/subtractor on the X and Z mux outputs, and registers the result (P) and carry-out (CARRYOUT).
- Feeds the P output bus, the Z-mux P-feedback path, and the CARRYOUT / CARRYOUTF pins.

Parameters:
- CARRYINREG, 1, 1 = carry-in passes through the CYI register; 0 = combinational bypass.
- PREG, 1, 1 = P register used; 0 = P is combinational.
- CARRYOUTREG, 1, 1 = carry-out register used; 0 = combinational.
- WIDTH, 48, post-adder operand and result width.

Ports:
- clk  input  1  datapath clock; all registers update on rising edge.
- rst  input  1  asynchronous, active-high global reset; clears all registers.
- rstcarryin  input  1  synchronous active-high reset of CYI register; priority over cecarryin.
- rstp  input  1  synchronous active-high reset of P and CARRYOUT registers; priority over cep.
- cecarryin  input  1  clock enable, CYI register.
- cep  input  1  clock enable, P and CARRYOUT registers.
- carryin_sel  input  1  selected carry-in from the carry-in select stage.
- opmode7  input  1  0 = add, 1 = subtract.
- x_in  input  WIDTH  X-mux output.
- z_in  input  WIDTH  Z-mux output.
- p  output  WIDTH  post-adder result.
- carryout  output  1  post-adder carry/borrow out.
- carryoutf  output  1  fabric copy of carryout; always identical to carryout.

Behaviour:
- Reset values:
  - rst=1 asynchronously forces cyi_q=0, p=0, carryout=0, carryoutf=0, independent of clk and of all enables.
  - Deassertion of rst takes effect at the next rising edge only.
- CYI register (CARRYINREG=1), per rising edge:
  - rstcarryin=1 -> cyi_q<=0.
  - else cecarryin=1 -> cyi_q<=carryin_sel.
  - else hold.
  - cin=cyi_q.
- CYI bypass (CARRYINREG=0): cin=carryin_sel; rstcarryin and cecarryin are ignored.
- Alignment:
  - With CARRYINREG=1, cin is one cycle behind carryin_sel.
  - x_in and z_in arrive in the same cycle as cin. Upstream aligns them through the M-path register, which sits in parallel with the CYI register.
- Arithmetic, 49-bit internal, operands zero-extended:
  - opmode7=0: r = Z + X + cin.
  - opmode7=1: r = Z - (X + cin).
  - result=r[WIDTH-1:0]; co=r[WIDTH].
  - For subtract, co=1 indicates borrow (Z < X+cin).
  - Wrap-around modulo 2^WIDTH; no saturation.
- P and CARRYOUT registers, per rising edge:
  - rstp=1 -> p<=0 and carryout<=0.
  - else cep=1 -> p<=result and carryout<=co.
  - else hold.
  - When PREG=0, p=result combinationally. When CARRYOUTREG=0, carryout=co combinationally.
  - rstp and cep govern each register only where that register is present.
- Latency, carryin_sel -> p with all registers enabled: 2 cycles. x_in/z_in -> p: 1 cycle.
- Simultaneous events:
  - Sync reset beats enable.
  - Async rst beats everything.
  - rst asserted mid-stream discards the in-flight carry and result. The first valid p after release appears PREG+CARRYINREG edges later.
- opmode7 is sampled in the same cycle as x_in/z_in; it is not registered here.

Test Plan:
- Reset: drive all inputs nonzero, pulse rst mid-cycle -> p=0, carryout=0, carryoutf=0 immediately, without waiting for a clk edge.
- Add with carry: carryin_sel=1 (cycle 0); X=0x0000_0000_0005, Z=0x0000_0000_0003, opmode7=0 (cycle 1) -> p=0x0000_0000_0009, carryout=0 after the cycle-1 edge.
- Overflow wrap: X=0xFFFF_FFFF_FFFF, Z=0x0000_0000_0001, cin=0, add -> p=0, carryout=1, carryoutf=1.
- Subtract with borrow: Z=0x0000_0000_0002, X=0x0000_0000_0002, cin=1, opmode7=1 -> p=0xFFFF_FFFF_FFFF, carryout=1. Repeat with Z=0x10 -> p=0xD, carryout=0.
- Enable/sync-reset priority: cep=0 for 3 cycles with changing inputs -> p holds. Then rstp=1 and cep=1 together -> p=0. cecarryin=0 with carryin_sel toggling -> cin holds its old value.
- Bypass config: CARRYINREG=0, PREG=0, CARRYOUTREG=0; X=0x7, Z=0x8, carryin_sel=1, add -> p=0x10 in the same cycle; rst has no visible effect on p.
